// File: rtl/angle_scheduler.sv
// Crank-angle event scheduler: interpolates engine angle between crank teeth and drives a
// timed output pulse when the interpolated angle reaches a configured start angle.
module angle_scheduler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger_i,
   input  logic        synced_i,
   input  logic [15:0] eng_phase_i,
   input  logic [31:0] tooth_period_i,
   input  logic [15:0] next_tooth_length_deg_i,
   input  logic        enable_i,
   input  logic [15:0] cycle_deg_i,
   input  logic [15:0] start_deg_i,
   input  logic [31:0] duration_i,
   output logic        out_o,
   output logic [15:0] angle_now_o,
   output logic        armed_o,
   output logic        cfg_err_o,
   output logic        sync_lost_o
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StArmed  = 2'd1;
   localparam logic [1:0] StActive = 2'd2;

   logic        trig_q;

   // Interpolation state
   logic [15:0] angle_q, angle_d;
   logic [15:0] deg_in_tooth_q, deg_in_tooth_d;
   logic [31:0] sub_cnt_q, sub_cnt_d;
   logic [15:0] tooth_deg_q, tooth_deg_d;
   logic [31:0] tpd_q, tpd_d;

   // Restoring divider state
   logic        div_busy_q, div_busy_d;
   logic [5:0]  div_cnt_q, div_cnt_d;
   logic [15:0] div_rem_q, div_rem_d;
   logic [31:0] div_quo_q, div_quo_d;
   logic [15:0] div_den_q, div_den_d;

   // Event FSM state
   logic [1:0]  state_q, state_d;
   logic        out_q, out_d;
   logic [31:0] dur_cnt_q, dur_cnt_d;
   logic        hit_ok_q, hit_ok_d;
   logic        sync_lost_q, sync_lost_d;

   logic        cfg_err;
   logic [16:0] div_shift;
   logic        div_ge;
   logic [15:0] div_diff;
   logic [31:0] div_quo_nxt;
   logic        sub_last;
   logic        angle_wrap;
   logic [15:0] angle_inc;
   logic        deg_room;
   logic        hit;

   assign cfg_err = (cycle_deg_i == 16'd0) || (start_deg_i >= cycle_deg_i);

   // One quotient bit per cycle; the remainder is always below the divisor, so 16 bits hold it.
   assign div_shift   = {div_rem_q, div_quo_q[31]};
   assign div_ge      = (div_shift >= {1'b0, div_den_q});
   assign div_diff    = div_shift[15:0] - div_den_q;
   assign div_quo_nxt = {div_quo_q[30:0], div_ge};

   always_comb begin
      div_busy_d = div_busy_q;
      div_cnt_d  = div_cnt_q;
      div_rem_d  = div_rem_q;
      div_quo_d  = div_quo_q;
      div_den_d  = div_den_q;
      tpd_d      = tpd_q;
      if (!synced_i) begin
         div_busy_d = 1'b0;
         div_cnt_d  = 6'd0;
         tpd_d      = 32'd0;
      end else if (trig_q) begin
         // A new tooth aborts any divide in flight and restarts with fresh operands.
         div_busy_d = 1'b1;
         div_cnt_d  = 6'd32;
         div_rem_d  = 16'd0;
         div_quo_d  = tooth_period_i;
         div_den_d  = tooth_deg_q;
      end else if (div_busy_q) begin
         div_rem_d = div_ge ? div_diff : div_shift[15:0];
         div_quo_d = div_quo_nxt;
         div_cnt_d = div_cnt_q - 6'd1;
         if (div_cnt_q == 6'd1) begin
            div_busy_d = 1'b0;
            if (div_den_q == 16'd0) begin
               tpd_d = 32'd0;
            end else if (div_quo_nxt == 32'd0) begin
               tpd_d = 32'd1;
            end else begin
               tpd_d = div_quo_nxt;
            end
         end
      end
   end

   assign sub_last   = (sub_cnt_q >= tpd_q - 32'd1);
   assign angle_wrap = (({1'b0, angle_q} + 17'd1) >= {1'b0, cycle_deg_i});
   assign angle_inc  = angle_wrap ? 16'd0 : angle_q + 16'd1;
   // Caps interpolation at the last degree of the current tooth.
   assign deg_room   = (({1'b0, deg_in_tooth_q} + 17'd1) < {1'b0, tooth_deg_q});

   always_comb begin
      angle_d        = angle_q;
      deg_in_tooth_d = deg_in_tooth_q;
      sub_cnt_d      = sub_cnt_q;
      tooth_deg_d    = tooth_deg_q;
      if (!synced_i) begin
         deg_in_tooth_d = 16'd0;
         sub_cnt_d      = 32'd0;
         tooth_deg_d    = 16'd0;
      end else if (trig_q) begin
         angle_d        = eng_phase_i;
         deg_in_tooth_d = 16'd0;
         sub_cnt_d      = 32'd0;
         tooth_deg_d    = next_tooth_length_deg_i;
      end else if (tpd_q != 32'd0) begin
         if (sub_last) begin
            sub_cnt_d = 32'd0;
            if (deg_room) begin
               deg_in_tooth_d = deg_in_tooth_q + 16'd1;
               angle_d        = angle_inc;
            end
         end else begin
            sub_cnt_d = sub_cnt_q + 32'd1;
         end
      end
   end

   // hit_ok re-opens only once the angle has moved off start_deg, giving one event per pass.
   assign hit = (angle_q == start_deg_i) && hit_ok_q;

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      dur_cnt_d   = dur_cnt_q;
      sync_lost_d = 1'b0;
      hit_ok_d    = (angle_q != start_deg_i) ? 1'b1 : hit_ok_q;
      if (!synced_i || !enable_i || cfg_err) begin
         state_d     = StIdle;
         out_d       = 1'b0;
         dur_cnt_d   = 32'd0;
         sync_lost_d = !synced_i && (state_q != StIdle);
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StArmed;
               out_d   = 1'b0;
            end
            StArmed: begin
               out_d = 1'b0;
               if (hit) begin
                  hit_ok_d = 1'b0;
                  if (duration_i != 32'd0) begin
                     state_d   = StActive;
                     out_d     = 1'b1;
                     dur_cnt_d = duration_i;
                  end
               end
            end
            StActive: begin
               if (dur_cnt_q <= 32'd1) begin
                  state_d   = StArmed;
                  out_d     = 1'b0;
                  dur_cnt_d = 32'd0;
               end else begin
                  out_d     = 1'b1;
                  dur_cnt_d = dur_cnt_q - 32'd1;
               end
            end
            default: begin
               state_d = StIdle;
               out_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q         <= 1'b0;
         angle_q        <= 16'd0;
         deg_in_tooth_q <= 16'd0;
         sub_cnt_q      <= 32'd0;
         tooth_deg_q    <= 16'd0;
         tpd_q          <= 32'd0;
         div_busy_q     <= 1'b0;
         div_cnt_q      <= 6'd0;
         div_rem_q      <= 16'd0;
         div_quo_q      <= 32'd0;
         div_den_q      <= 16'd0;
         state_q        <= StIdle;
         out_q          <= 1'b0;
         dur_cnt_q      <= 32'd0;
         hit_ok_q       <= 1'b0;
         sync_lost_q    <= 1'b0;
      end else begin
         trig_q         <= trigger_i;
         angle_q        <= angle_d;
         deg_in_tooth_q <= deg_in_tooth_d;
         sub_cnt_q      <= sub_cnt_d;
         tooth_deg_q    <= tooth_deg_d;
         tpd_q          <= tpd_d;
         div_busy_q     <= div_busy_d;
         div_cnt_q      <= div_cnt_d;
         div_rem_q      <= div_rem_d;
         div_quo_q      <= div_quo_d;
         div_den_q      <= div_den_d;
         state_q        <= state_d;
         out_q          <= out_d;
         dur_cnt_q      <= dur_cnt_d;
         hit_ok_q       <= hit_ok_d;
         sync_lost_q    <= sync_lost_d;
      end
   end

   assign out_o       = out_q;
   assign angle_now_o = angle_q;
   assign armed_o     = (state_q == StArmed);
   assign cfg_err_o   = cfg_err;
   assign sync_lost_o = sync_lost_q;

endmodule

// File: tb/tb_angle_scheduler.sv
// Bench for angle_scheduler: a tooth-level reference model queues expected angle changes and
// pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_angle_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trigger = 1'b0;
   logic        synced = 1'b0;
   logic [15:0] eng_phase = '0;
   logic [31:0] tooth_period = '0;
   logic [15:0] next_tooth_length_deg = '0;
   logic        enable = 1'b0;
   logic [15:0] cycle_deg = 16'd720;
   logic [15:0] start_deg = '0;
   logic [31:0] duration = '0;
   logic        out;
   logic [15:0] angle_now;
   logic        armed;
   logic        cfg_err;
   logic        sync_lost;

   angle_scheduler dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .trigger_i               (trigger),
      .synced_i                (synced),
      .eng_phase_i             (eng_phase),
      .tooth_period_i          (tooth_period),
      .next_tooth_length_deg_i (next_tooth_length_deg),
      .enable_i                (enable),
      .cycle_deg_i             (cycle_deg),
      .start_deg_i             (start_deg),
      .duration_i              (duration),
      .out_o                   (out),
      .angle_now_o             (angle_now),
      .armed_o                 (armed),
      .cfg_err_o               (cfg_err),
      .sync_lost_o             (sync_lost)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int unsigned t; int unsigned v; } ang_ev_t;
   typedef struct { int unsigned rise; int unsigned width; } pulse_t;

   ang_ev_t ang_q[$];
   pulse_t  pul_q[$];
   int      n_cmp = 0;
   int      n_err = 0;
   bit      mon_en = 1'b0;

   // Reference model state, per tooth rather than per clock
   int unsigned m_start, m_dur, m_last_fall, m_tpd, m_tooth, m_cdeg;
   bit          m_cerr;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   logic [15:0] last_ang = '0;
   logic        last_out = 1'b0;
   int unsigned rise_c = 0;
   int unsigned exp_w = 0;
   ang_ev_t     mon_ev;
   pulse_t      mon_p;

   always @(negedge clk) begin
      if (mon_en) begin
         if (angle_now != last_ang) begin
            if (ang_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL angle_unexpected: got %0d, expected no change (cycle %0d)",
                        angle_now, cyc);
            end else begin
               mon_ev = ang_q.pop_front();
               check("angle_value", angle_now, mon_ev.v);
               check("angle_time", cyc, mon_ev.t);
            end
         end
         if (out && !last_out) begin
            if (pul_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pulse_unexpected: got rise at cycle %0d, expected none", cyc);
            end else begin
               mon_p = pul_q.pop_front();
               check("pulse_rise", cyc, mon_p.rise);
               exp_w  = mon_p.width;
               rise_c = cyc;
            end
         end
         if (!out && last_out) check("pulse_width", cyc - rise_c, exp_w);
      end
      last_ang = angle_now;
      last_out = out;
   end

   task automatic push_ev(input int unsigned v, input int unsigned t);
      ang_ev_t e;
      pulse_t  p;
      e.v = v;
      e.t = t;
      ang_q.push_back(e);
      if (!m_cerr && m_dur != 0 && v == m_start && t >= m_last_fall) begin
         p.rise  = t + 1;
         p.width = m_dur;
         pul_q.push_back(p);
         m_last_fall = t + m_dur + 1;
      end
   endtask

   task automatic do_reset();
      mon_en  = 1'b0;
      trigger = 1'b0;
      synced  = 1'b0;
      enable  = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ang_q.delete();
      pul_q.delete();
      check("rst_angle", angle_now, 0);
      check("rst_out", out, 0);
      check("rst_armed", armed, 0);
      check("rst_sync_lost", sync_lost, 0);
   endtask

   task automatic setup_case(input int unsigned cdeg, input int unsigned st, input int unsigned d);
      do_reset();
      cycle_deg   = 16'(cdeg);
      start_deg   = 16'(st);
      duration    = d;
      synced      = 1'b1;
      enable      = 1'b1;
      m_cdeg      = cdeg;
      m_start     = st;
      m_dur       = d;
      m_cerr      = (cdeg == 0) || (st >= cdeg);
      m_last_fall = 0;
      m_tpd       = 0;
      m_tooth     = 0;
      repeat (3) @(posedge clk);
      #1;
      check("cfg_err", cfg_err, m_cerr ? 1 : 0);
      check("armed_on_enable", armed, m_cerr ? 0 : 1);
      mon_en = 1'b1;
   endtask

   // Angle advances one degree per (period / previous tooth length) clocks, 33 clocks after the
   // tooth when no rate was known yet, otherwise immediately at the old rate.
   task automatic issue_tooth(input int unsigned ph, input int unsigned tp, input int unsigned n);
      int unsigned tr, ntpd, use_tpd, base;
      @(posedge clk);
      #1;
      trigger               = 1'b1;
      eng_phase             = 16'(ph);
      tooth_period          = tp;
      next_tooth_length_deg = 16'(n);
      tr = cyc + 1;
      if (m_tooth == 0) ntpd = 0;
      else ntpd = (tp / m_tooth == 0) ? 1 : tp / m_tooth;
      push_ev(ph, tr + 1);
      use_tpd = 0;
      base    = 0;
      if (m_tpd != 0) begin
         use_tpd = m_tpd;
         base    = tr + 1;
      end else if (ntpd != 0) begin
         use_tpd = ntpd;
         base    = tr + 33;
      end
      if (use_tpd != 0)
         for (int m = 1; m < int'(n); m++) push_ev((ph + m) % m_cdeg, base + m * use_tpd);
      m_tpd   = ntpd;
      m_tooth = n;
      @(posedge clk);
      #1;
      trigger = 1'b0;
   endtask

   task automatic drain_and_check();
      for (int w = 0; w < 3000; w++) begin
         if (ang_q.size() == 0 && pul_q.size() == 0 && cyc > m_last_fall + 2) break;
         @(posedge clk);
      end
      #1;
      check("angle_queue_drained", ang_q.size(), 0);
      check("pulse_queue_drained", pul_q.size(), 0);
      check("armed_end", armed, m_cerr ? 0 : 1);
      check("out_end", out, 0);
      mon_en = 1'b0;
   endtask

   task automatic run_case(input int unsigned cdeg, input int unsigned p0, input int unsigned n,
                           input int unsigned k, input int unsigned st, input int unsigned d,
                           input int unsigned teeth);
      int unsigned tp;
      setup_case(cdeg, st, d);
      for (int i = 0; i < int'(teeth); i++) begin
         tp = n * k + $urandom_range(n - 1, 0);
         issue_tooth((p0 + i * n) % cdeg, tp, n);
         repeat (40 + n * ((k == 0) ? 1 : k) + $urandom_range(20, 0)) @(posedge clk);
      end
      drain_and_check();
   endtask

   task automatic wait_out_high(input string name);
      bit seen = 1'b0;
      for (int w = 0; w < 3000; w++) begin
         @(posedge clk);
         #1;
         if (out) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, seen, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cd, n, k, p0, st, d;

      // Two teeth of 10 deg at 360 clk/deg; event at 105 lasting 500 clk
      run_case(720, 90, 10, 360, 105, 500, 2);
      // Wrap through cycle_deg with the event at 2 deg
      run_case(720, 705, 10, 20, 2, 30, 3);
      // Start angle outside the cycle: cfg_err and no pulse
      run_case(720, 50, 10, 20, 720, 100, 3);
      // Zero duration: hit consumed, no pulse, stays armed
      run_case(720, 50, 10, 20, 65, 0, 3);
      // Tooth period shorter than tooth length: rate saturates to 1 clk/deg
      run_case(360, 30, 8, 0, 45, 5, 3);

      for (int r = 0; r < 6; r++) begin
         cd = (r % 2 == 0) ? 720 : 360;
         n  = $urandom_range(12, 4);
         k  = $urandom_range(60, 1);
         p0 = $urandom_range(cd - 1, 1);
         st = (p0 + n + $urandom_range(2 * n, 0)) % cd;
         d  = $urandom_range(150, 1);
         run_case(cd, p0, n, k, st, d, 4);
      end

      // Sync loss mid-pulse
      p0 = $urandom_range(600, 1);
      st = p0 + 12;
      setup_case(720, st, 200);
      issue_tooth(p0, 300, 10);
      repeat (350) @(posedge clk);
      issue_tooth(p0 + 10, 300 + $urandom_range(9, 0), 10);
      wait_out_high("sync_test_out_seen");
      @(negedge clk);
      mon_en = 1'b0;
      synced = 1'b0;
      @(posedge clk);
      #1;
      check("sync_drop_out", out, 0);
      check("sync_drop_pulse", sync_lost, 1);
      check("sync_drop_armed", armed, 0);
      @(posedge clk);
      #1;
      check("sync_lost_one_cycle", sync_lost, 0);
      repeat (100) @(posedge clk);
      #1;
      check("sync_drop_angle_halted", angle_now, st);
      check("sync_drop_out_stays_low", out, 0);

      // Asynchronous reset mid-pulse
      p0 = $urandom_range(600, 1);
      setup_case(720, p0 + 13, 300);
      issue_tooth(p0, 200, 10);
      repeat (250) @(posedge clk);
      issue_tooth(p0 + 10, 200, 10);
      wait_out_high("reset_test_out_seen");
      @(negedge clk);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out", out, 0);
      check("async_rst_angle", angle_now, 0);
      check("async_rst_armed", armed, 0);
      check("async_rst_sync_lost", sync_lost, 0);
      repeat (2) @(posedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
